ex_hazard_forward_ctrl: RTL and testbench
=========================================

Name: ex_hazard_forward_ctrl

Overview:
- Sequencing controller for the execute stage of the 8-bit pipeline.
- Tracks destination/write info of in-flight instructions in EX, MEM and WB with its own shadow pipeline.
- Generates registered forwarding selects for the EX-stage operand A/B forwarding muxes.
- Detects load-use hazards (stall plus bubble) and handles taken-branch flushes.

Parameters:
REG_ADDR_WIDTH, 3, width of register specifiers (8-entry register file)
R0_HARDWIRED, 1, when 1 a write to register 0 never matches, so no forwarding from it
STALL_CNT_WIDTH, 16, width of saturating stall performance counter

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rs1  input  REG_ADDR_WIDTH  ID source register 1 (feeds ALU input A)
id_rs2  input  REG_ADDR_WIDTH  ID source register 2 (feeds ALU input B path)
id_uses_rs1  input  1  instruction reads rs1
id_uses_rs2  input  1  instruction reads rs2 (0 when ALU B takes disp/const)
id_rd  input  REG_ADDR_WIDTH  ID destination register
id_reg_write  input  1  instruction writes register file
id_mem_read  input  1  instruction is a load
branch_taken  input  1  branch in EX resolved taken this cycle
stall  output  1  hold PC and IF/ID register (combinational)
id_ex_bubble  output  1  load NOP into ID/EX register this edge (combinational)
flush_if_id  output  1  invalidate IF/ID register this edge (combinational)
aluInputAForwardingSel  output  2  registered select: 00 register file, 01 Ex_Mem result, 10 Mem_Wb result
aluInputBForwardingSel  output  2  same encoding for operand B
stall_count  output  STALL_CNT_WIDTH  saturating count of load-use stall cycles

Behaviour:
- Reset (async, immediate): all shadow valid/write bits 0, rd fields 0, both forwarding selects 00, stall_count 0. stall/id_ex_bubble/flush_if_id therefore 0.
- Shadow pipeline: fields {rw, mr, rd} for EX, MEM and WB slots. Every edge: WB<=MEM, MEM<=EX. EX loads ID fields when id_valid and not stall and not branch_taken. Otherwise EX loads a bubble (rw=0, mr=0, rd=0).
- match(slot, r): slot.rw=1 and slot.rd==r, and not (R0_HARDWIRED and r==0).
- Forwarding (registered, valid while the instruction occupies EX). On each edge that loads ID into EX:
  - A sel <= 01 if id_uses_rs1 and match(EX, id_rs1); else 10 if id_uses_rs1 and match(MEM, id_rs1); else 00.
  - B uses id_uses_rs2 and id_rs2 identically.
  - EX slot has priority over MEM slot (newest value wins).
  - When EX loads a bubble, both selects <= 00.
  - Code 11 is never driven.
- Load-use hazard, combinational: hz = id_valid and EX.mr and EX.rw and ((id_uses_rs1 and match(EX, id_rs1)) or (id_uses_rs2 and match(EX, id_rs2))).
  - stall = hz and not branch_taken. id_ex_bubble = stall or branch_taken.
  - Exactly one stall cycle per load-use. Next cycle the load sits in MEM, EX is a bubble, and the consumer gets sel 10.
- Branch: flush_if_id = branch_taken.
  - Flush has priority over stall: stall is forced 0 and the ID instruction is discarded (bubble).
  - The EX branch itself proceeds to MEM normally.
- stall_count increments by 1 on each edge with stall=1 and saturates at all-ones.
- No handshake with memory. Every stage advances every cycle except IF/ID under stall.
- Async reset mid-stall clears everything. The first instruction after reset sees no hazards.

Test Plan:
- Distance-1 RAW: ADD r3 then SUB reading r3 as rs1 on next cycle -> in SUB's EX cycle aluInputAForwardingSel=01, B=00, stall never asserted.
- Distance-2 RAW on B: write r5, independent instr, then instr with id_uses_rs2=1 rs2=r5 -> aluInputBForwardingSel=10 in its EX cycle.
- Priority: two consecutive writes to r2 followed by read of r2 on rs1 -> A sel=01 (not 10).
- Load-use: LOAD r4 then ADD rs1=r4 -> stall=1 and id_ex_bubble=1 for exactly one cycle; stall_count 0->1; ADD enters EX next cycle with A sel=10.
- Branch over hazard: load r4 in EX, ADD r4 in ID, branch_taken=1 same cycle -> stall=0, flush_if_id=1, id_ex_bubble=1; next cycle both selects 00, stall_count unchanged.
- R0 and reset: write r0 then read r0 -> sel 00 (R0_HARDWIRED=1). Assert rst during a stall cycle -> stall, selects, stall_count go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/ex_hazard_forward_ctrl.sv
// Execute-stage sequencing controller: shadow pipeline of in-flight destinations,
// registered operand forwarding selects, load-use stall/bubble and branch flush.
module ex_hazard_forward_ctrl #(
    parameter int REG_ADDR_WIDTH  = 3,
    parameter bit R0_HARDWIRED    = 1'b1,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs2,
    input  logic                       id_uses_rs1,
    input  logic                       id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rd,
    input  logic                       id_reg_write,
    input  logic                       id_mem_read,
    input  logic                       branch_taken,
    output logic                       stall,
    output logic                       id_ex_bubble,
    output logic                       flush_if_id,
    output logic [1:0]                 aluInputAForwardingSel,
    output logic [1:0]                 aluInputBForwardingSel,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_EX_MEM  = 2'b01,
        FWD_MEM_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                      rw;
        logic                      mr;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } slot_t;

    localparam slot_t BUBBLE = '{rw: 1'b0, mr: 1'b0, rd: '0};

    // The WB instruction's result is already readable from the register file,
    // so only the EX and MEM slots can influence a select and are stored here.
    slot_t    ex_q,  ex_d;
    slot_t    mem_q, mem_d;
    fwd_sel_e sel_a_q, sel_a_d;
    fwd_sel_e sel_b_q, sel_b_d;
    logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    logic hazard;
    logic load_id;

    function automatic logic match(input slot_t s, input logic [REG_ADDR_WIDTH-1:0] r);
        return s.rw && (s.rd == r) && !(R0_HARDWIRED && (r == '0));
    endfunction

    function automatic fwd_sel_e pick_src(input logic uses, input logic [REG_ADDR_WIDTH-1:0] r,
                                          input slot_t ex_s, input slot_t mem_s);
        if (uses && match(ex_s, r)) return FWD_EX_MEM;
        if (uses && match(mem_s, r)) return FWD_MEM_WB;
        return FWD_REGFILE;
    endfunction

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        hazard = 1'b0;
        if (id_valid && ex_q.mr && ex_q.rw &&
            ((id_uses_rs1 && match(ex_q, id_rs1)) || (id_uses_rs2 && match(ex_q, id_rs2))))
            hazard = 1'b1;
    end

    // A taken branch discards the ID instruction, so it overrides the stall.
    assign stall        = hazard && !branch_taken;
    assign id_ex_bubble = stall || branch_taken;
    assign flush_if_id  = branch_taken;
    assign load_id      = id_valid && !stall && !branch_taken;

    always_comb begin
        ex_d          = BUBBLE;
        mem_d         = ex_q;
        sel_a_d       = FWD_REGFILE;
        sel_b_d       = FWD_REGFILE;
        stall_count_d = stall_count_q;

        if (load_id) begin
            ex_d.rw = id_reg_write;
            ex_d.mr = id_mem_read;
            ex_d.rd = id_rd;
            sel_a_d = pick_src(id_uses_rs1, id_rs1, ex_q, mem_q);
            sel_b_d = pick_src(id_uses_rs2, id_rs2, ex_q, mem_q);
        end

        if (stall && (stall_count_q != '1))
            stall_count_d = stall_count_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the async reset clears all state immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q          <= BUBBLE;
            mem_q         <= BUBBLE;
            sel_a_q       <= FWD_REGFILE;
            sel_b_q       <= FWD_REGFILE;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            sel_a_q       <= sel_a_d;
            sel_b_q       <= sel_b_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign aluInputAForwardingSel = sel_a_q;
    assign aluInputBForwardingSel = sel_b_q;
    assign stall_count            = stall_count_q;

endmodule

// File: tb/tb_ex_hazard_forward_ctrl.sv
// Scenario bench for ex_hazard_forward_ctrl: expected selects are queued when an
// instruction is presented in ID and compared once it occupies EX.
module tb_ex_hazard_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
    logic        branch_taken;
    logic        stall, id_ex_bubble, flush_if_id;
    logic [1:0]  sel_a, sel_b;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_q[$];

    ex_hazard_forward_ctrl #(
        .REG_ADDR_WIDTH(3), .R0_HARDWIRED(1'b1), .STALL_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .branch_taken(branch_taken),
        .stall(stall), .id_ex_bubble(id_ex_bubble), .flush_if_id(flush_if_id),
        .aluInputAForwardingSel(sel_a), .aluInputBForwardingSel(sel_b),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present one ID instruction for one cycle; checks the combinational controls,
    // queues the selects it should see in EX, then compares them after the edge.
    task automatic step(input string tag, input logic v,
                        input logic [2:0] rs1, input logic u1,
                        input logic [2:0] rs2, input logic u2,
                        input logic [2:0] rd, input logic rw, input logic mr,
                        input logic br, input logic exp_stall,
                        input logic [1:0] ea, input logic [1:0] eb);
        logic [3:0] e;
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; branch_taken = br;
        #1;
        check({tag, ".stall"},  stall,        exp_stall);
        check({tag, ".bubble"}, id_ex_bubble, exp_stall | br);
        check({tag, ".flush"},  flush_if_id,  br);
        exp_q.push_back({ea, eb});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".selA"}, sel_a, e[3:2]);
            check({tag, ".selB"}, sel_b, e[1:0]);
        end
    endtask

    task automatic nop2();
        step("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        step("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_reg_write = 0; id_mem_read = 0;
        branch_taken = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.stall", stall, 0);
        check("reset.selA", sel_a, 2'b00);
        check("reset.selB", sel_b, 2'b00);
        check("reset.count", stall_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Distance-1 RAW on A
        step("add_r3", 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00);
        step("sub_r3", 1, 3, 1, 1, 1, 6, 1, 0, 0, 0, 2'b01, 2'b00);
        nop2();

        // Distance-2 RAW on B
        step("wr_r5",  1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00);
        step("indep",  1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("rd_r5b", 1, 7, 1, 5, 1, 7, 1, 0, 0, 0, 2'b00, 2'b10);
        nop2();

        // Newest writer wins; unused rs2 never forwards
        step("wr_r2a", 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 2'b00, 2'b00);
        step("wr_r2b", 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 2'b00, 2'b00);
        step("rd_r2",  1, 2, 1, 2, 0, 3, 1, 0, 0, 0, 2'b01, 2'b00);
        nop2();

        // Load-use: one stall, then MEM/WB forward
        check("lu.count0", stall_count, 0);
        step("ld_r4",   1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 2'b00);
        step("add_stl", 1, 4, 1, 0, 1, 5, 1, 0, 0, 1, 2'b00, 2'b00);
        check("lu.count1", stall_count, 1);
        step("add_go",  1, 4, 1, 0, 1, 5, 1, 0, 0, 0, 2'b10, 2'b00);
        check("lu.count_hold", stall_count, 1);
        nop2();

        // Branch over a load-use hazard
        step("ld_r4b",  1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 2'b00);
        step("br_flush",1, 4, 1, 0, 0, 5, 1, 0, 1, 0, 2'b00, 2'b00);
        check("br.count", stall_count, 1);
        step("after_br",1, 0, 0, 4, 1, 5, 1, 0, 0, 0, 2'b00, 2'b10);
        nop2();

        // Register 0 never forwards or stalls
        step("wr_r0",  1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00);
        step("rd_r0",  1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("ld_r0",  1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00);
        step("rd_r0b", 1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00);
        nop2();

        // Async reset in the middle of a stall
        step("wr_r6",  1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 2'b00, 2'b00);
        step("ld_r4c", 1, 6, 1, 0, 0, 4, 1, 1, 0, 0, 2'b01, 2'b00);
        @(negedge clk);
        id_valid = 1; id_rs1 = 4; id_uses_rs1 = 1; id_rs2 = 6; id_uses_rs2 = 1;
        id_rd = 2; id_reg_write = 1; id_mem_read = 0; branch_taken = 0;
        #1;
        check("mid.stall_pre", stall, 1);
        check("mid.selA_pre", sel_a, 2'b01);
        check("mid.count_pre", stall_count, 1);
        rst = 1'b1;
        #1;
        check("mid.stall_rst", stall, 0);
        check("mid.bubble_rst", id_ex_bubble, 0);
        check("mid.selA_rst", sel_a, 2'b00);
        check("mid.count_rst", stall_count, 0);
        @(negedge clk);
        rst = 1'b0;
        step("first_post", 1, 4, 1, 6, 1, 2, 1, 0, 0, 0, 2'b00, 2'b00);
        check("end.count", stall_count, 0);
        check("end.queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
